// File: rtl/banner_scroller_pkg.sv
// Shared types, constants and width helper for the banner scroller
// and its prescaler.
package banner_pkg;

    typedef enum logic {
        WRAP   = 1'b0,
        BOUNCE = 1'b1
    } mode_e;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } bdir_e;

    localparam logic [4:0] SYM_BLANK = 5'h10;

    // Address/counter width for n entries, never narrower than one bit.
    function automatic int clog2w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/banner_scroller_tick_prescaler.sv
// Free-running divide-by-DIV prescaler; emits a registered one-cycle
// advance request each time the count wraps.
module tick_prescaler
    import banner_pkg::*;
#(
    parameter int DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = clog2w(DIV);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Count 0..DIV-1 while enabled; hold (not clear) when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else if (en) begin
            if (cnt_r == CW'(DIV - 1)) begin
                cnt_r  <= {CW{1'b0}};
                tick_r <= 1'b1;
            end else begin
                cnt_r  <= cnt_r + CW'(1);
                tick_r <= 1'b0;
            end
        end else begin
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/banner_scroller.sv
// Rotating-banner engine: message buffer, position/direction FSM,
// step edge detector and registered DIGITS-wide display window.
module banner_scroller
    import banner_pkg::*;
#(
    parameter int DIGITS   = 6,
    parameter int MSG_LEN  = 10,
    parameter int SYM_W    = 5,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            dir,
    input  logic                            mode,
    input  logic                            step,
    input  logic                            wr_en,
    input  logic [clog2w(MSG_LEN)-1:0]      wr_addr,
    input  logic [SYM_W-1:0]                wr_data,
    output logic [DIGITS*SYM_W-1:0]         digits,
    output logic [clog2w(MSG_LEN)-1:0]      pos,
    output logic                            tick,
    output logic                            wrap
);

    localparam int AW      = clog2w(MSG_LEN);
    localparam int MAX_POS = MSG_LEN - DIGITS;

    logic [SYM_W-1:0]        msg_r [MSG_LEN];
    logic [AW-1:0]           pos_r, pos_nxt_s;
    bdir_e                   bdir_r, bdir_nxt_s;
    logic                    tick_r, wrap_r, wrap_nxt_s;
    logic [DIGITS*SYM_W-1:0] digits_r, digits_nxt_s;
    logic                    step_r, step_d_r;
    logic                    auto_req_s, man_req_s, adv_s;
    mode_e                   mode_s;

    tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (auto_req_s)
    );

    // Index of window slot k, wrapped modulo MSG_LEN.
    function automatic logic [AW-1:0] win_idx(input logic [AW-1:0] p, input int k);
        logic [AW:0] sum;
        sum = {1'b0, p} + (AW+1)'(k);
        if (sum >= (AW+1)'(MSG_LEN)) begin
            sum = sum - (AW+1)'(MSG_LEN);
        end else begin
            sum = sum;
        end
        return sum[AW-1:0];
    endfunction

    assign mode_s    = mode_e'(mode);
    assign man_req_s = step_r & ~step_d_r;
    assign adv_s     = auto_req_s | man_req_s;

    // Step synchroniser stage plus previous-value register for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_r   <= 1'b0;
            step_d_r <= 1'b0;
        end else begin
            step_r   <= step;
            step_d_r <= step_r;
        end
    end

    // Message buffer; out-of-range addresses are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_r[i] <= SYM_W'(i % 16);
            end
        end else if (wr_en && (int'(wr_addr) < MSG_LEN)) begin
            msg_r[wr_addr] <= wr_data;
        end
    end

    // Next position, bounce direction and wrap pulse for one advance.
    always_comb begin
        pos_nxt_s  = pos_r;
        bdir_nxt_s = bdir_r;
        wrap_nxt_s = 1'b0;
        case (mode_s)
            WRAP: begin
                bdir_nxt_s = dir ? UP : DOWN;
                if (adv_s) begin
                    if (dir) begin
                        if (pos_r == AW'(MSG_LEN - 1)) begin
                            pos_nxt_s  = {AW{1'b0}};
                            wrap_nxt_s = 1'b1;
                        end else begin
                            pos_nxt_s = pos_r + AW'(1);
                        end
                    end else begin
                        if (pos_r == {AW{1'b0}}) begin
                            pos_nxt_s  = AW'(MSG_LEN - 1);
                            wrap_nxt_s = 1'b1;
                        end else begin
                            pos_nxt_s = pos_r - AW'(1);
                        end
                    end
                end else begin
                    pos_nxt_s = pos_r;
                end
            end
            BOUNCE: begin
                if (!adv_s) begin
                    pos_nxt_s = pos_r;
                end else if (MAX_POS == 0) begin
                    pos_nxt_s  = {AW{1'b0}};
                    wrap_nxt_s = 1'b1;
                end else if (pos_r > AW'(MAX_POS)) begin
                    // Entered bounce outside the range: clamp and head down.
                    pos_nxt_s  = AW'(MAX_POS);
                    bdir_nxt_s = DOWN;
                    wrap_nxt_s = 1'b1;
                end else if (bdir_r == UP) begin
                    if (pos_r == AW'(MAX_POS)) begin
                        pos_nxt_s  = AW'(MAX_POS - 1);
                        bdir_nxt_s = DOWN;
                        wrap_nxt_s = 1'b1;
                    end else begin
                        pos_nxt_s = pos_r + AW'(1);
                    end
                end else begin
                    if (pos_r == {AW{1'b0}}) begin
                        pos_nxt_s  = AW'(1);
                        bdir_nxt_s = UP;
                        wrap_nxt_s = 1'b1;
                    end else begin
                        pos_nxt_s = pos_r - AW'(1);
                    end
                end
            end
            default: begin
                pos_nxt_s  = pos_r;
                bdir_nxt_s = bdir_r;
                wrap_nxt_s = 1'b0;
            end
        endcase
    end

    // Window contents from the current position and buffer.
    always_comb begin
        digits_nxt_s = {(DIGITS*SYM_W){1'b0}};
        for (int k = 0; k < DIGITS; k++) begin
            digits_nxt_s[k*SYM_W +: SYM_W] = msg_r[win_idx(pos_r, k)];
        end
    end

    // Position/direction state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_r  <= {AW{1'b0}};
            bdir_r <= UP;
            tick_r <= 1'b0;
            wrap_r <= 1'b0;
            for (int k = 0; k < DIGITS; k++) begin
                digits_r[k*SYM_W +: SYM_W] <= SYM_W'(k % 16);
            end
        end else begin
            pos_r    <= pos_nxt_s;
            bdir_r   <= bdir_nxt_s;
            tick_r   <= adv_s;
            wrap_r   <= wrap_nxt_s;
            digits_r <= digits_nxt_s;
        end
    end

    assign digits = digits_r;
    assign pos    = pos_r;
    assign tick   = tick_r;
    assign wrap   = wrap_r;

endmodule

// File: doc/banner_scroller.md
# banner_scroller

Parametrised rotating-banner engine for the multiplexed seven-segment display path. Holds a writable message buffer of `MSG_LEN` symbols and presents a `DIGITS`-wide window onto it. The window advances at a prescaled rate in wrap-around or bounce mode, or by single-step pulses. Its packed `digits` output feeds the display multiplexer directly, replacing the fixed six-digit rotator.

## Interface

Parameters:
- `DIGITS`, 6: display slots driven.
- `MSG_LEN`, 10: message buffer depth in symbols; must be ≥ `DIGITS`.
- `SYM_W`, 5: symbol code width as consumed by the display mux; must be ≥ 4.
- `TICK_DIV`, 25_000_000: clock cycles per automatic advance; must be ≥ 2. This gives 2 Hz at 50 MHz.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: enables the prescaler; when low, the prescaler count freezes.
- `dir` in 1: wrap-mode direction; 1 means `pos` increments, 0 means it decrements.
- `mode` in 1: 0 selects wrap, 1 selects bounce.
- `step` in 1: manual advance request; level input, rising-edge detected internally.
- `wr_en` in 1: message write strobe.
- `wr_addr` in `$clog2(MSG_LEN)`: write address.
- `wr_data` in `SYM_W`: symbol to write.
- `digits` out `DIGITS*SYM_W`: slot k occupies bits [k*SYM_W +: SYM_W].
- `pos` out `$clog2(MSG_LEN)`: current window start index.
- `tick` out 1: one-cycle pulse on every advance, whether automatic or manual.
- `wrap` out 1: one-cycle pulse when `pos` wraps in wrap mode, or reverses in bounce mode.

## Operation

- Message buffer, `MSG_LEN` × `SYM_W` registers:
  - Reset value: entry i = i mod 16.
  - Writes with `wr_en`=1 and `wr_addr` < `MSG_LEN` update the entry at the edge.
  - Writes with `wr_addr` ≥ `MSG_LEN` are ignored.
- Window: slot k = `msg[(pos + k) mod MSG_LEN]`, computed from the current `pos` and buffer contents, then registered into `digits`.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 while `en`=1.
  - At terminal count it returns to 0 and raises an automatic advance request.
  - `en`=0 holds the count; it does not clear it.
- Step: `step` is registered once, and a 0→1 transition raises a manual advance request.
- Advance rule:
  - Automatic and manual requests in the same cycle produce exactly one advance and one `tick`.
  - Manual advance works regardless of `en`.
- Wrap mode (`mode`=0):
  - `dir`=1: `pos` ← `pos`+1; at `MSG_LEN`-1 it goes to 0 and pulses `wrap`.
  - `dir`=0: `pos` ← `pos`-1; at 0 it goes to `MSG_LEN`-1 and pulses `wrap`.
- Bounce mode (`mode`=1):
  - Range is 0..MAX, where MAX = `MSG_LEN`-`DIGITS`. Internal direction bit `bdir`: UP or DOWN.
  - UP and `pos` < MAX: `pos`+1.
  - UP and `pos` = MAX: `bdir` ← DOWN, `pos` ← MAX-1, `wrap` pulses.
  - DOWN mirrors UP at 0.
  - MAX = 0: `pos` stays 0; `wrap` pulses on every advance.
  - `pos` > MAX on an advance (after a mode switch): `pos` ← MAX, `bdir` ← DOWN, `wrap` pulses.
- While `mode`=0, `bdir` tracks `dir` each cycle (1 = UP), so bounce starts in the last wrap direction.
- Reset mid-operation: all state returns to reset values immediately, with no partial advance. A write coincident with reset deassertion is lost.

## Timing

- Reset values:
  - `pos`=0.
  - Slot k of `digits` = k mod 16, consistent with the reset buffer contents.
  - `tick`=0, `wrap`=0, prescaler=0, `bdir`=UP, step register=0.
- Advance latency:
  - Request cycle N: `pos`, `tick` and `wrap` update at edge N.
  - `digits` reflects the new `pos` at edge N+1.
- Write latency: buffer updates at edge N; an affected slot shows the new symbol at edge N+1.
- Step latency: `step` rising sampled at edge N; advance at edge N+1.
- Automatic period: exactly `TICK_DIV` cycles between `tick` pulses with `en` held high and no manual requests.
- Manual advances do not reset the prescaler.

## Structure

- Package `banner_pkg`:
  - `mode_e` (WRAP=0, BOUNCE=1).
  - `bdir_e` (DOWN=0, UP=1).
  - `SYM_BLANK` symbol constant.
  - Helper function computing `$clog2` widths.
- Sub-module `tick_prescaler`, parameter `DIV`, ports `clk`, `rst_n`, `en` and `tick`. The top-level holds the buffer, position/direction FSM, window registers and step edge detector.

## Test plan

- Reset with defaults, `TICK_DIV`=4, `en`=1, `dir`=1, `mode`=0 → `digits` slots 0,1,2,3,4,5; `tick` every 4 cycles; after 10 ticks `pos`=0 and `wrap` pulses once.
- `dir`=0 from reset, one tick → `pos`=9; next cycle slots are 9,0,1,2,3,4; `wrap` pulses.
- `mode`=1, `en`=1 → `pos` goes 0,1,2,3,4,3,2,1,0,1; `wrap` pulses at the 4→3 and 0→1 reversals.
- `en`=0, `step` pulses high for 3 cycles each, three times → `pos` 0→3, one `tick` per pulse; a step rising on the same cycle as a prescaler terminal count gives a single advance.
- Write `wr_addr`=2, `wr_data`=5'h1F at `pos`=0 → slot 2 = 1F one cycle later; a write to `wr_addr`=12 leaves all slots unchanged.
- Wrap mode at `pos`=8, then switch to bounce and step → `pos`=4, `bdir`=DOWN, `wrap` pulses; assert `rst_n` mid-run → outputs return to reset values immediately.
